ps2_scancode_decoder: RTL and testbench

Consumes the raw byte stream from the PS/2 keyboard receiver (received_data / received_data_en) and turns Set-2 scancodes into key events. Strips the E0 (extended), F0 (break) and E1 (Pause) prefixes and drops keyboard status bytes. Tracks Shift/Ctrl/Alt modifier levels. Queues events in a small FIFO with a valid/ready pop port for the CPU-side keyboard controller.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_event_fifo.sv | 47 ++++
 rtl/ps2_scancode_decoder.sv | 133 +++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared scancode constants, FSM states and event record for the PS/2 decoder.
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, PAUSE} ps2_state_e;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [7:0] PAUSE_CODE = 8'h77;
  localparam logic [7:0] ST_BAT = 8'hAA;
  localparam logic [7:0] ST_ACK = 8'hFA;
  localparam logic [7:0] ST_ECHO = 8'hEE;
  localparam logic [7:0] ST_RESEND = 8'hFE;
  localparam logic [7:0] ST_ERR0 = 8'h00;
  localparam logic [7:0] ST_ERR1 = 8'hFF;
  localparam logic [7:0] MOD_LSHIFT = 8'h12;
  localparam logic [7:0] MOD_RSHIFT = 8'h59;
  localparam logic [7:0] MOD_CTRL = 8'h14;
  localparam logic [7:0] MOD_ALT = 8'h11;
  typedef struct packed {
    logic rel;
    logic ext;
    logic [7:0] code;
  } ps2_event_t;
  function automatic logic is_status(input logic [7:0] b);
    return b == ST_BAT || b == ST_ACK || b == ST_ECHO || b == ST_RESEND || b == ST_ERR0 || b == ST_ERR1;
  endfunction
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous event FIFO with a registered head entry.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  ps2_event_t din,
  input  logic       pop,
  output ps2_event_t dout,
  output logic       valid,
  output logic       drop
);
  localparam int AW = $clog2(DEPTH);
  ps2_event_t mem [DEPTH];
  ps2_event_t head_nx;
  logic [AW:0] wr, rd, wr_nx, rd_nx;
  logic empty, full, pop_do, push_do;
  always_comb begin
    empty = wr == rd;
    full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    pop_do = pop && !empty;
    push_do = push && (!full || pop_do);
    drop = push && !push_do;
    rd_nx = rd + (AW+1)'(pop_do);
    wr_nx = wr + (AW+1)'(push_do);
    // a push landing in the new head slot bypasses the memory read
    head_nx = (wr_nx == rd_nx) ? '0 :
              (push_do && wr[AW-1:0] == rd_nx[AW-1:0]) ? din : mem[rd_nx[AW-1:0]];
  end
  always_ff @(posedge clock)
    if (push_do) mem[wr[AW-1:0]] <= din;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr <= '0;
      rd <= '0;
      dout <= '0;
      valid <= 1'b0;
    end else begin
      wr <= wr_nx;
      rd <= rd_nx;
      dout <= head_nx;
      valid <= wr_nx != rd_nx;
    end
endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: Set-2 byte stream to key events with modifier tracking and event FIFO.
// Optional PS2DEC_TIMEOUT_EN aborts a stalled prefix sequence after TIMEOUT_CYCLES idle clocks.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       mod_shift,
  output logic       mod_ctrl,
  output logic       mod_alt,
  output logic [7:0] status_byte,
  output logic       status_valid,
  output logic       overflow,
  input  logic       ovf_clr
);
  ps2_state_e state, state_nx;
  logic [2:0] pcnt, pcnt_nx;
  logic emit, st_hit, drop;
  ps2_event_t ev, head;
  logic lshift, rshift, lctrl, rctrl, lalt, ralt;
`ifdef PS2DEC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) tmo <= TW'(TIMEOUT_CYCLES - 1);
    else if (state == IDLE || rx_valid) tmo <= TW'(TIMEOUT_CYCLES - 1);
    else if (tmo != '0) tmo <= tmo - 1'b1;
`endif
  always_comb begin
    state_nx = state;
    pcnt_nx = pcnt;
    emit = 1'b0;
    st_hit = 1'b0;
    ev = '0;
    if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_data == PS2_EXT) state_nx = EXT;
          else if (rx_data == PS2_BRK) state_nx = BRK;
          else if (rx_data == PS2_PAUSE) begin
            state_nx = PAUSE;
            pcnt_nx = '0;
          end else if (is_status(rx_data)) st_hit = 1'b1;
          else begin
            emit = 1'b1;
            ev = '{rel: 1'b0, ext: 1'b0, code: rx_data};
          end
        end
        EXT: begin
          if (rx_data == PS2_BRK) state_nx = EXTBRK;
          else if (rx_data != PS2_EXT) begin
            emit = 1'b1;
            ev = '{rel: 1'b0, ext: 1'b1, code: rx_data};
            state_nx = IDLE;
          end
        end
        BRK: begin
          emit = 1'b1;
          ev = '{rel: 1'b1, ext: 1'b0, code: rx_data};
          state_nx = IDLE;
        end
        EXTBRK: begin
          emit = 1'b1;
          ev = '{rel: 1'b1, ext: 1'b1, code: rx_data};
          state_nx = IDLE;
        end
        PAUSE: begin
          pcnt_nx = pcnt + 3'd1;
          if (pcnt == 3'd6) begin
            emit = 1'b1;
            ev = '{rel: 1'b0, ext: 1'b1, code: PAUSE_CODE};
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
`ifdef PS2DEC_TIMEOUT_EN
    else if (state != IDLE && tmo == '0) state_nx = IDLE;
`endif
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      pcnt <= '0;
      status_byte <= '0;
      status_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      pcnt <= pcnt_nx;
      status_valid <= st_hit;
      if (st_hit) status_byte <= rx_data;
      overflow <= drop ? 1'b1 : ovf_clr ? 1'b0 : overflow;
    end
  // left and right sources tracked separately so releasing one side keeps the other held
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) {lshift, rshift, lctrl, rctrl, lalt, ralt} <= '0;
    else if (emit) begin
      if (!ev.ext && ev.code == MOD_LSHIFT) lshift <= !ev.rel;
      if (!ev.ext && ev.code == MOD_RSHIFT) rshift <= !ev.rel;
      if (!ev.ext && ev.code == MOD_CTRL) lctrl <= !ev.rel;
      if (ev.ext && ev.code == MOD_CTRL) rctrl <= !ev.rel;
      if (!ev.ext && ev.code == MOD_ALT) lalt <= !ev.rel;
      if (ev.ext && ev.code == MOD_ALT) ralt <= !ev.rel;
    end
  assign mod_shift = lshift | rshift;
  assign mod_ctrl = lctrl | rctrl;
  assign mod_alt = lalt | ralt;
  ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset_n(reset_n),
    .push(emit),
    .din(ev),
    .pop(key_ready),
    .dout(head),
    .valid(key_valid),
    .drop(drop)
  );
  assign key_code = head.code;
  assign key_ext = head.ext;
  assign key_release = head.rel;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: table-driven vectors with an expected-event scoreboard queue.
module tb_ps2_scancode_decoder;
  import ps2_pkg::*;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic key_ready = 1'b0;
  logic ovf_clr = 1'b0;
  logic [7:0] key_code, status_byte;
  logic key_ext, key_release, key_valid, mod_shift, mod_ctrl, mod_alt, status_valid, overflow;
  int checks = 0;
  int failures = 0;
  ps2_event_t exp_q[$];
  typedef struct {
    logic [63:0] bytes;
    int n;
    logic [7:0] code;
    logic ext;
    logic rel;
    logic [2:0] mods;
  } vec_t;
  vec_t tv[17];
  always #5 clock = ~clock;
  ps2_scancode_decoder #(
`ifdef PS2DEC_TIMEOUT_EN
    .TIMEOUT_CYCLES(50),
`endif
    .FIFO_DEPTH(8)
  ) dut (
    .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .key_code(key_code), .key_ext(key_ext), .key_release(key_release),
    .key_valid(key_valid), .key_ready(key_ready), .mod_shift(mod_shift),
    .mod_ctrl(mod_ctrl), .mod_alt(mod_alt), .status_byte(status_byte),
    .status_valid(status_valid), .overflow(overflow), .ovf_clr(ovf_clr)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic send_seq(input logic [63:0] bytes, input int n);
    for (int j = 0; j < n; j++) begin
      rx_data = bytes[8*(n-1-j) +: 8];
      rx_valid = 1'b1;
      @(posedge clock);
      #1;
    end
    rx_valid = 1'b0;
  endtask
  task automatic expect_ev(input logic [7:0] code, input logic ext, input logic rel);
    exp_q.push_back('{rel: rel, ext: ext, code: code});
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  always @(negedge clock) begin
    if (reset_n && key_valid && key_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual=%h required=none", {key_release, key_ext, key_code});
      end else begin
        chk("event", 32'({key_release, key_ext, key_code}), 32'(exp_q.pop_front()));
      end
    end
  end
  initial begin
    tv[0]  = '{64'h1C, 1, 8'h1C, 1'b0, 1'b0, 3'b000};
    tv[1]  = '{64'hF01C, 2, 8'h1C, 1'b0, 1'b1, 3'b000};
    tv[2]  = '{64'hE075, 2, 8'h75, 1'b1, 1'b0, 3'b000};
    tv[3]  = '{64'hE0F075, 3, 8'h75, 1'b1, 1'b1, 3'b000};
    tv[4]  = '{64'hE011, 2, 8'h11, 1'b1, 1'b0, 3'b001};
    tv[5]  = '{64'hE0F011, 3, 8'h11, 1'b1, 1'b1, 3'b000};
    tv[6]  = '{64'h12, 1, 8'h12, 1'b0, 1'b0, 3'b100};
    tv[7]  = '{64'hE012, 2, 8'h12, 1'b1, 1'b0, 3'b100};
    tv[8]  = '{64'hE0F012, 3, 8'h12, 1'b1, 1'b1, 3'b100};
    tv[9]  = '{64'hF012, 2, 8'h12, 1'b0, 1'b1, 3'b000};
    tv[10] = '{64'hE014, 2, 8'h14, 1'b1, 1'b0, 3'b010};
    tv[11] = '{64'h14, 1, 8'h14, 1'b0, 1'b0, 3'b010};
    tv[12] = '{64'hE0F014, 3, 8'h14, 1'b1, 1'b1, 3'b010};
    tv[13] = '{64'hF014, 2, 8'h14, 1'b0, 1'b1, 3'b000};
    tv[14] = '{64'hE0E06B, 3, 8'h6B, 1'b1, 1'b0, 3'b000};
    tv[15] = '{64'h59, 1, 8'h59, 1'b0, 1'b0, 3'b100};
    tv[16] = '{64'hF059, 2, 8'h59, 1'b0, 1'b1, 3'b000};
    #12;
    chk("reset_key_valid", 32'(key_valid), 32'd0);
    chk("reset_mods", 32'({mod_shift, mod_ctrl, mod_alt}), 32'd0);
    chk("reset_status", 32'({status_valid, status_byte}), 32'd0);
    chk("reset_head", 32'({key_release, key_ext, key_code}), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_cyc(2);
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_seq(64'h1C, 1);
    chk("latency_valid", 32'(key_valid), 32'd1);
    chk("latency_head", 32'({key_release, key_ext, key_code}), 32'h01C);
    wait_cyc(3);
    chk("head_stable", 32'({key_valid, key_code}), 32'h11C);
    key_ready = 1'b1;
    wait_cyc(2);
    chk("drained_after_pop", 32'(key_valid), 32'd0);
    for (int i = 0; i < 17; i++) begin
      expect_ev(tv[i].code, tv[i].ext, tv[i].rel);
      send_seq(tv[i].bytes, tv[i].n);
      wait_cyc(2);
      chk($sformatf("mods_v%0d", i), 32'({mod_shift, mod_ctrl, mod_alt}), 32'(tv[i].mods));
      chk($sformatf("popped_v%0d", i), 32'(exp_q.size()), 32'd0);
    end
    expect_ev(PAUSE_CODE, 1'b1, 1'b0);
    send_seq(64'hE11477E1F014F077, 8);
    wait_cyc(3);
    chk("pause_ctrl", 32'(mod_ctrl), 32'd0);
    chk("pause_one_event", 32'(exp_q.size()), 32'd0);
    send_seq(64'hAA, 1);
    chk("status_aa", 32'({status_valid, status_byte}), 32'h1AA);
    wait_cyc(1);
    chk("status_pulse_end", 32'(status_valid), 32'd0);
    send_seq(64'hFA, 1);
    chk("status_fa", 32'({status_valid, status_byte}), 32'h1FA);
    wait_cyc(2);
    chk("status_no_event", 32'(key_valid), 32'd0);
    key_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) expect_ev(8'(8'h20 + i), 1'b0, 1'b0);
      rx_data = 8'(8'h20 + i);
      rx_valid = 1'b1;
      @(posedge clock);
      #1;
    end
    rx_valid = 1'b0;
    wait_cyc(1);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_head", 32'({key_valid, key_code}), 32'h120);
    key_ready = 1'b1;
    wait_cyc(12);
    chk("ovf_drained", 32'({key_valid, 8'(exp_q.size())}), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    wait_cyc(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
`ifdef PS2DEC_TIMEOUT_EN
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_seq(64'hE0, 1);
    wait_cyc(60);
    send_seq(64'h1C, 1);
    wait_cyc(2);
    chk("timeout_event", 32'(exp_q.size()), 32'd0);
`endif
    expect_ev(8'h12, 1'b0, 1'b0);
    send_seq(64'h12, 1);
    wait_cyc(2);
    send_seq(64'hF0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(key_valid), 32'd0);
    chk("rst_mid_mods", 32'({mod_shift, mod_ctrl, mod_alt}), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_cyc(1);
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_seq(64'h1C, 1);
    wait_cyc(3);
    chk("rst_idle_make", 32'(mod_shift), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
